// File: rtl/cnn_single_layer.sv
// cnn_single_layer: single-channel convolution layer.
// Multiplies Image/Filter sample pairs, sums KERNEL products into one
// window result, stores results in a small FIFO-ordered buffer and
// returns them one per cycle on ConvResult when ReadEn is asserted.
module cnn_single_layer #(
  parameter int KERNEL = 3,
  parameter int DEPTH  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Start,
  input  logic [3:0] Image,
  input  logic [3:0] Filter,
  input  logic       ReadEn,
  output logic [9:0] ConvResult
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] READ = 2'd2;

  localparam int CNT_W = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [9:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [9:0]       buffer [DEPTH];

  logic [7:0]       product;
  logic             new_frame;
  logic [9:0]       acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [PTR_W-1:0] wr_base;
  logic             window_done;
  logic [9:0]       window_sum;
  logic             buffer_full;
  logic             read_valid;

  assign product = Image * Filter;

  // Next-state logic: Start always wins over ReadEn.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Start)       state_next = CONV;
        else if (ReadEn) state_next = READ;
      end
      CONV: begin
        if (!Start) state_next = IDLE;
      end
      READ: begin
        if (Start)        state_next = CONV;
        else if (!ReadEn) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath view of the current edge: a rising Start begins a new frame,
  // so the sample captured on that edge is treated as the first of a window.
  always_comb begin
    new_frame   = Start && (state != CONV);
    acc_base    = new_frame ? '0 : acc;
    cnt_base    = new_frame ? '0 : cnt;
    wr_base     = new_frame ? '0 : wr_ptr;
    window_done = (cnt_base == CNT_W'(KERNEL - 1));
    window_sum  = acc_base + {2'b00, product};
    buffer_full = (wr_base == PTR_W'(DEPTH));
    read_valid  = (rd_ptr < wr_ptr);
  end

  // Accumulate, store completed windows, and serve reads when Start is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ConvResult <= '0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      state <= state_next;
      if (Start) begin
        if (new_frame) rd_ptr <= '0;
        if (window_done) begin
          if (!buffer_full) begin
            buffer[wr_base[IDX_W-1:0]] <= window_sum;
            wr_ptr <= wr_base + 1'b1;
          end else begin
            wr_ptr <= wr_base;
          end
          acc <= '0;
          cnt <= '0;
        end else begin
          acc    <= window_sum;
          cnt    <= cnt_base + 1'b1;
          wr_ptr <= wr_base;
        end
      end else begin
        acc <= '0;
        cnt <= '0;
        if (ReadEn) begin
          if (read_valid) begin
            ConvResult <= buffer[rd_ptr[IDX_W-1:0]];
            rd_ptr     <= rd_ptr + 1'b1;
          end else begin
            ConvResult <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_single_layer.sv
// Testbench for cnn_single_layer: directed stimulus pushes hand-computed
// expectations into a queue; a monitor pops and compares after each edge
// where the stimulus marked ConvResult as meaningful.
module tb_cnn_single_layer;

  logic       clk;
  logic       rst_n;
  logic       Start;
  logic [3:0] Image;
  logic [3:0] Filter;
  logic       ReadEn;
  logic [9:0] ConvResult;

  int assertCount = 0;
  int failCount   = 0;
  int expQueue[$];
  bit checkNow     = 0;
  bit checkLatched = 0;

  cnn_single_layer #(.KERNEL(3), .DEPTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Start(Start),
    .Image(Image),
    .Filter(Filter),
    .ReadEn(ReadEn),
    .ConvResult(ConvResult)
  );

  // 10 ns clock.
  initial clk = 0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; optionally queue the ConvResult expected after the edge.
  task automatic applyStimulus(input logic s, input logic [3:0] im, input logic [3:0] f,
                               input logic re, input bit chk, input int expVal);
    @(negedge clk);
    Start  = s;
    Image  = im;
    Filter = f;
    ReadEn = re;
    if (chk) expQueue.push_back(expVal);
    checkNow = chk;
    @(posedge clk);
  endtask

  // Remember which edges carry a checked result.
  always @(posedge clk) checkLatched <= checkNow;

  // Monitor: compare ConvResult midway through the cycle after a checked edge.
  always @(negedge clk) begin
    if (checkLatched) begin
      if (expQueue.size() == 0) begin
        checkOutput("scoreboard_underflow", 1, 0);
      end else begin
        checkOutput("ConvResult", int'(ConvResult), expQueue.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int imgA[15] = '{1, 2, 3, 2, 3, 4, 3, 4, 5, 4, 5, 6, 5, 6, 7};
    int expA[7]  = '{14, 20, 26, 32, 38, 0, 0};

    Start = 0; Image = 0; Filter = 0; ReadEn = 0;
    rst_n = 0;
    #12;
    checkOutput("reset_value", int'(ConvResult), 0);
    @(negedge clk);
    rst_n = 1;

    // Five windows, then seven reads (two past the end).
    for (int i = 0; i < 15; i++)
      applyStimulus(1, 4'(imgA[i]), 4'(i % 3 + 1), 0, 0, 0);
    for (int i = 0; i < 7; i++)
      applyStimulus(0, 4'd0, 4'd0, 1, 1, expA[i]);
    applyStimulus(0, 4'd0, 4'd0, 0, 1, 0);

    // Same frame again: single read pulses with hold in between.
    for (int i = 0; i < 15; i++)
      applyStimulus(1, 4'(imgA[i]), 4'(i % 3 + 1), 0, 0, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 14);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 4'd0, 4'd0, 0, 1, 14);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 20);

    // Maximum window value.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 4'd15, 4'd15, 0, 0, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 675);

    // Start has priority over ReadEn: ConvResult holds while a new frame streams.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 4'd1, 4'd1, 1, 1, 675);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 3);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 0);

    // Partial window discarded when Start drops.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 4'd1, 4'd1, 0, 0, 0);
    applyStimulus(1, 4'd2, 4'd2, 0, 0, 0);
    applyStimulus(0, 4'd0, 4'd0, 0, 0, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 3);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 0);

    // Nine windows into an eight-entry buffer: the ninth is dropped.
    for (int i = 0; i < 27; i++)
      applyStimulus(1, 4'd1, 4'd1, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      applyStimulus(0, 4'd0, 4'd0, 1, 1, (i < 8) ? 3 : 0);

    // Two windows stored, one read, then reset discards the rest.
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 4'd1, 4'd1, 0, 0, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 3);
    @(negedge clk);
    checkNow = 0;
    ReadEn = 0;
    #2;
    rst_n = 0;
    #1;
    checkOutput("async_reset_clear", int'(ConvResult), 0);
    @(negedge clk);
    rst_n = 1;
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 0);
    applyStimulus(0, 4'd0, 4'd0, 1, 1, 0);

    applyStimulus(0, 4'd0, 4'd0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", expQueue.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
